// File: rtl/scaler_v_line_pack.sv
// -----------------------------------------------------------------------------
// scaler_v_line_pack
//
// Purpose:
//   Repacks the sparse pixel stream from the vertical scaler into gap-free
//   lines. Each complete input line is captured into one bank of a two-bank
//   ping-pong RAM. It is then re-emitted as a contiguous burst (de_o high every
//   cycle), preceded by at least max(h_gap,1) idle cycles.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   line_size     pixels per line, sampled at each input line start
//   h_gap         minimum idle cycles before each output line (0 acts as 1)
//   di_i/de_i     input pixel and its valid
//   hs_i/vs_i     line / frame start markers, qualified by de_i
//   do_o/de_o     output pixel and valid (do_o holds while de_o=0)
//   hs_o/vs_o     first-pixel-of-line / first-line-of-frame pulses
//   ovf_o         sticky: an input line was dropped (no free bank)
//   ovf_cnt_o     dropped-line counter
//
// Optional feature:
//   SCALER_V_LINE_PACK_OVF_CNT_EN - when defined, ovf_cnt_o is a saturating
//   16-bit count of dropped lines. When undefined, ovf_cnt_o is tied to 0.
// -----------------------------------------------------------------------------
module scaler_v_line_pack #(
   parameter int DATA_WIDTH    = 8,
   parameter int LINE_SIZE_MAX = 1024,
   parameter int ADDR_WIDTH    = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [15:0]           line_size,
   input  logic [15:0]           h_gap,
   input  logic [DATA_WIDTH-1:0] di_i,
   input  logic                  de_i,
   input  logic                  hs_i,
   input  logic                  vs_i,
   output logic [DATA_WIDTH-1:0] do_o,
   output logic                  de_o,
   output logic                  hs_o,
   output logic                  vs_o,
   output logic                  ovf_o,
   output logic [15:0]           ovf_cnt_o
);

   localparam int DEPTH = 2 ** (ADDR_WIDTH + 1);

   typedef enum logic [1:0] {IDLE, GAP, ACTIVE} rd_state_e;

   // ---------------------------------------------------------------- storage
   logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];
   logic [DATA_WIDTH-1:0] rd_data_q;

   // Per-bank state. last_q holds the address of the last pixel (len-1).
   logic [1:0]                 full_q, full_d;
   logic [1:0][ADDR_WIDTH-1:0] last_q;
   logic [1:0]                 sof_q;

   // ------------------------------------------------------------- write side
   logic                  wr_bank_q;
   logic [ADDR_WIDTH-1:0] wr_cnt_q;
   // hold_q: ignore non-start pixels. It covers "no line start seen since
   // reset", "line dropped", and "line already complete".
   logic                  hold_q;
   logic                  ovf_q;

   logic                  line_start;
   logic                  wr_full;
   logic                  we;
   logic [ADDR_WIDTH-1:0] wa;
   logic                  line_last;
   logic [15:0]           ls_clamp;
   logic [ADDR_WIDTH-1:0] last_new;

   // ------------------------------------------------------------- read side
   rd_state_e             state_q;
   logic                  rd_bank_q;
   logic [ADDR_WIDTH-1:0] rd_addr_q;
   logic [15:0]           gap_cnt_q;
   logic [15:0]           gap_load;
   logic                  rd_issue;
   logic                  rd_last;

   // Output pipeline stage 1 (alongside the registered RAM read).
   logic s1_vld_q, s1_hs_q, s1_sof_q;

   assign line_start = de_i & (hs_i | vs_i);
   assign wr_full    = full_q[wr_bank_q];

   always_comb begin
      ls_clamp = line_size;
      if (line_size == 16'd0)
         ls_clamp = 16'd1;
      else if (line_size > 16'(LINE_SIZE_MAX))
         ls_clamp = 16'(LINE_SIZE_MAX);
   end

   assign last_new = ADDR_WIDTH'(ls_clamp - 16'd1);
   assign gap_load = (h_gap == 16'd0) ? 16'd1 : h_gap;

   // A line start always restarts at address 0, even mid-line. This discards
   // a partial line without touching wr_bank or the full flags.
   always_comb begin
      we        = 1'b0;
      wa        = wr_cnt_q;
      line_last = 1'b0;
      if (line_start) begin
         if (!wr_full) begin
            we        = 1'b1;
            wa        = '0;
            line_last = (last_new == '0);
         end
      end else if (de_i && !hold_q) begin
         we        = 1'b1;
         line_last = (wr_cnt_q == last_q[wr_bank_q]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_bank_q <= 1'b0;
         wr_cnt_q  <= '0;
         hold_q    <= 1'b1;
         ovf_q     <= 1'b0;
         last_q    <= '0;
         sof_q     <= '0;
      end else begin
         if (line_start) begin
            if (wr_full) begin
               hold_q <= 1'b1;
               ovf_q  <= 1'b1;
            end else begin
               hold_q            <= line_last;
               last_q[wr_bank_q] <= last_new;
               sof_q[wr_bank_q]  <= vs_i;
               wr_cnt_q          <= ADDR_WIDTH'(1);
            end
         end else if (we) begin
            wr_cnt_q <= wr_cnt_q + ADDR_WIDTH'(1);
            if (line_last)
               hold_q <= 1'b1;
         end
         if (line_last)
            wr_bank_q <= ~wr_bank_q;
      end
   end

   // The writer sets the flag of wr_bank and the reader clears the flag of
   // rd_bank. These are never the same bank in a cycle where both fire.
   always_comb begin
      full_d = full_q;
      if (line_last) full_d[wr_bank_q] = 1'b1;
      if (rd_last)   full_d[rd_bank_q] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) full_q <= '0;
      else     full_q <= full_d;
   end

   // RAM: one write port and one registered read port, not reset.
   always_ff @(posedge clk) begin
      if (we)
         mem_q[{wr_bank_q, wa}] <= di_i;
      if (rd_issue)
         rd_data_q <= mem_q[{rd_bank_q, rd_addr_q}];
   end

   // -------------------------------------------------------------- read FSM
   assign rd_issue = (state_q == ACTIVE);
   assign rd_last  = rd_issue && (rd_addr_q == last_q[rd_bank_q]);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         rd_bank_q <= 1'b0;
         rd_addr_q <= '0;
         gap_cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (full_q[rd_bank_q]) begin
                  state_q   <= GAP;
                  gap_cnt_q <= gap_load;
               end
            end
            GAP: begin
               if (gap_cnt_q == 16'd1) begin
                  state_q   <= ACTIVE;
                  rd_addr_q <= '0;
               end else begin
                  gap_cnt_q <= gap_cnt_q - 16'd1;
               end
            end
            ACTIVE: begin
               rd_addr_q <= rd_addr_q + ADDR_WIDTH'(1);
               if (rd_last) begin
                  rd_bank_q <= ~rd_bank_q;
                  state_q   <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // ------------------------------------------------------- output pipeline
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld_q <= 1'b0;
         s1_hs_q  <= 1'b0;
         s1_sof_q <= 1'b0;
         do_o     <= '0;
         de_o     <= 1'b0;
         hs_o     <= 1'b0;
         vs_o     <= 1'b0;
      end else begin
         s1_vld_q <= rd_issue;
         s1_hs_q  <= rd_issue && (rd_addr_q == '0);
         s1_sof_q <= sof_q[rd_bank_q];
         de_o     <= s1_vld_q;
         hs_o     <= s1_hs_q;
         vs_o     <= s1_hs_q & s1_sof_q;
         if (s1_vld_q)
            do_o <= rd_data_q;
      end
   end

   assign ovf_o = ovf_q;

`ifdef SCALER_V_LINE_PACK_OVF_CNT_EN
   logic [15:0] ovf_cnt_q;

   always_ff @(posedge clk) begin
      if (rst)
         ovf_cnt_q <= '0;
      else if (line_start && wr_full && (ovf_cnt_q != 16'hFFFF))
         ovf_cnt_q <= ovf_cnt_q + 16'd1;
   end

   assign ovf_cnt_o = ovf_cnt_q;
`else
   assign ovf_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_scaler_v_line_pack.sv
// -----------------------------------------------------------------------------
// tb_scaler_v_line_pack
//
// Randomised and directed stimulus for scaler_v_line_pack. The reference model
// works at the line level. A line that completes at edge c starts its gap once
// the reader is free. Its first read issues max(h_gap,1)+1 edges after that.
// Its pixels appear on de_o one edge per pixel, starting one edge after the
// first issue. A new line is dropped if the line two completions back still
// occupies its bank.
// -----------------------------------------------------------------------------
module tb_scaler_v_line_pack;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [15:0]   line_size, h_gap;
   logic [DW-1:0] di_i;
   logic          de_i, hs_i, vs_i;
   logic [DW-1:0] do_o;
   logic          de_o, hs_o, vs_o, ovf_o;
   logic [15:0]   ovf_cnt_o;

   scaler_v_line_pack #(.DATA_WIDTH(DW), .LINE_SIZE_MAX(1024), .ADDR_WIDTH(10)) dut (
      .clk(clk), .rst(rst), .line_size(line_size), .h_gap(h_gap),
      .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
      .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o),
      .ovf_o(ovf_o), .ovf_cnt_o(ovf_cnt_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [DW-1:0] d;
      logic          hs;
      logic          vs;
      int            cyc;
   } beat_t;

   beat_t exp_q[$];
   int    checks = 0, failures = 0;
   bit    mon_en = 0;

   // Line-level model state.
   int r_end[$];    // edge of the last read issue of each completed line
   int r_prev = 0;  // reader-free reference edge
   int exp_drops = 0;
   bit exp_ovf = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset(input int rst_edge);
      r_end.delete();
      r_prev    = rst_edge;
      exp_drops = 0;
      exp_ovf   = 0;
   endtask

   task automatic model_complete(input int c, input logic [DW-1:0] pix[$], input bit sof);
      int g, start, t0;
      beat_t b;
      g     = (h_gap == 16'd0) ? 1 : int'(h_gap);
      start = (c + 1 > r_prev + 1) ? c + 1 : r_prev + 1;
      t0    = start + g + 1;
      for (int i = 0; i < pix.size(); i++) begin
         b.d   = pix[i];
         b.hs  = (i == 0);
         b.vs  = (i == 0) && sof;
         b.cyc = t0 + 1 + i;
         exp_q.push_back(b);
      end
      r_prev = t0 + pix.size() - 1;
      r_end.push_back(r_prev);
   endtask

   // Send npix pixels starting with a line start. Idle spacing between
   // pixels is random within [sp_min, sp_max].
   task automatic send_line(input int npix, input bit vs, input int lsz,
                            input int sp_min, input int sp_max, input int base);
      int e;
      bit drop;
      logic [DW-1:0] v;
      logic [DW-1:0] pix[$];
      drop      = 0;
      line_size = 16'(lsz);
      for (int i = 0; i < npix; i++) begin
         if (i > 0) repeat ($urandom_range(sp_max, sp_min)) tick();
         v    = DW'(base + i);
         di_i = v;
         de_i = 1'b1;
         hs_i = (i == 0);
         vs_i = (i == 0) && vs;
         e    = cyc + 1;
         if (i == 0) begin
            drop = (r_end.size() >= 2) && (r_end[r_end.size() - 2] >= e);
            if (drop) begin
               exp_ovf = 1;
               exp_drops++;
            end
         end
         if (!drop && pix.size() < lsz) begin
            pix.push_back(v);
            if (pix.size() == lsz) model_complete(e, pix, vs);
         end
         tick();
         de_i = 1'b0;
         hs_i = 1'b0;
         vs_i = 1'b0;
      end
   endtask

   task automatic drain(input string tag);
      int k;
      k = 0;
      while (exp_q.size() > 0 && k < 5000) begin
         tick();
         k++;
      end
      checks++;
      if (exp_q.size() > 0) begin
         failures++;
         $display("FAIL drain_%s: %0d beats still pending, required 0", tag, exp_q.size());
         exp_q.delete();
      end
      repeat (5) tick();
   endtask

   task automatic check_ovf(input string tag);
      logic [15:0] ec;
`ifdef SCALER_V_LINE_PACK_OVF_CNT_EN
      ec = (exp_drops > 65535) ? 16'hFFFF : 16'(exp_drops);
`else
      ec = 16'd0;
`endif
      checks++;
      if (ovf_o !== exp_ovf || ovf_cnt_o !== ec) begin
         failures++;
         $display("FAIL ovf_%s: got ovf=%0b cnt=%0d, required ovf=%0b cnt=%0d",
                  tag, ovf_o, ovf_cnt_o, exp_ovf, ec);
      end
   endtask

   // Monitor: compares every de_o beat with the scoreboard, flags missing
   // beats, and checks that hs/vs never fire outside a beat.
   always @(negedge clk) begin
      if (mon_en) begin
         checks++;
         if (de_o) begin
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL beat_unexpected: cyc=%0d do=%02h hs=%0b vs=%0b, required no output",
                        cyc, do_o, hs_o, vs_o);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               if (do_o !== e.d || hs_o !== e.hs || vs_o !== e.vs || cyc != e.cyc) begin
                  failures++;
                  $display("FAIL beat: got cyc=%0d do=%02h hs=%0b vs=%0b, required cyc=%0d do=%02h hs=%0b vs=%0b",
                           cyc, do_o, hs_o, vs_o, e.cyc, e.d, e.hs, e.vs);
               end
            end
         end else begin
            if (hs_o !== 1'b0 || vs_o !== 1'b0) begin
               failures++;
               $display("FAIL idle_marks: cyc=%0d hs=%0b vs=%0b, required 0 0", cyc, hs_o, vs_o);
            end
            if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
               failures++;
               $display("FAIL beat_missing: cyc=%0d de=0, required beat do=%02h at cyc=%0d",
                        cyc, exp_q[0].d, exp_q[0].cyc);
               void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      int ok;
      rst = 1'b1; line_size = 16'd4; h_gap = 16'd2;
      di_i = '0; de_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      model_reset(cyc);
      mon_en = 1;
      checks++;
      if (do_o !== 0 || de_o !== 0 || hs_o !== 0 || vs_o !== 0 || ovf_o !== 0 || ovf_cnt_o !== 0) begin
         failures++;
         $display("FAIL reset_state: do=%02h de=%0b hs=%0b vs=%0b ovf=%0b cnt=%0d, required all 0",
                  do_o, de_o, hs_o, vs_o, ovf_o, ovf_cnt_o);
      end

      // Stray pixels before any line start are ignored.
      repeat (3) begin
         di_i = 8'hEE; de_i = 1'b1; tick();
      end
      de_i = 1'b0;
      repeat (10) tick();

      // One line, a pixel every third cycle.
      h_gap = 16'd2;
      send_line(4, 1, 4, 2, 2, 8'h10);
      drain("single");

      // Three back-to-back lines, vs on the first only.
      send_line(4, 1, 4, 0, 0, 8'h20);
      send_line(4, 0, 4, 0, 0, 8'h30);
      send_line(4, 0, 4, 0, 0, 8'h40);
      drain("three");

      // Long gap: the third line finds both banks full.
      h_gap = 16'd200;
      send_line(4, 1, 4, 0, 0, 8'h50);
      send_line(4, 0, 4, 0, 0, 8'h60);
      send_line(4, 0, 4, 0, 0, 8'h70);
      drain("overflow");
      check_ovf("overflow");

      // Short line discarded. Extra pixels past len are ignored.
      h_gap = 16'd2;
      send_line(2, 0, 4, 0, 1, 8'h90);
      send_line(4, 0, 4, 0, 1, 8'hA0);
      send_line(6, 0, 4, 0, 1, 8'hB0);
      drain("short");

      // Full-size line, h_gap of 0.
      h_gap = 16'd0;
      send_line(1024, 1, 1024, 0, 0, $urandom_range(255, 0));
      drain("max_line");

      // Random batches.
      for (int b = 0; b < 3; b++) begin
         h_gap = 16'($urandom_range(6, 0));
         for (int l = 0; l < 10; l++) begin
            int lsz, kind, np;
            lsz  = $urandom_range(12, 1);
            kind = $urandom_range(9, 0);
            np   = (kind == 0) ? lsz - 1 : (kind == 1) ? lsz + 2 : lsz;
            if (np < 1) np = 1;
            send_line(np, $urandom_range(3, 0) == 0, lsz, 0, 2, $urandom_range(255, 0));
            repeat ($urandom_range(6, 0)) tick();
         end
         drain("random");
         check_ovf("random");
      end

      // Reset in the middle of an output burst.
      h_gap = 16'd1;
      send_line(8, 1, 8, 0, 0, 8'hC0);
      ok = 0;
      for (int k = 0; k < 100 && !ok; k++) begin
         tick();
         if (de_o) ok = 1;
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL burst_start_timeout: de_o=0 for 100 cycles, required burst");
      end
      tick();
      tick();
      rst = 1'b1;
      while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
      model_reset(cyc + 1);
      tick();
      rst = 1'b0;
      checks++;
      if (de_o !== 1'b0 || hs_o !== 1'b0 || vs_o !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_burst: de=%0b hs=%0b vs=%0b, required 0 0 0", de_o, hs_o, vs_o);
      end
      check_ovf("after_reset");
      repeat (3) tick();
      send_line(5, 1, 5, 0, 1, 8'hD0);
      drain("post_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/scaler_v_line_pack.md
Name: scaler_v_line_pack

Overview:
- Downstream stage of the vertical scaler. Consumes its sparse output stream: pixels with gaps, hs pulse on first pixel of each line, vs pulse on first pixel of each frame.
- Buffers each complete line in a two-bank ping-pong RAM.
- Re-emits each line as a contiguous burst (de high every cycle) with a programmable minimum blanking gap between lines.
- Feeds the output timing / encoder stage with gap-free lines.

Parameters:
- DATA_WIDTH, 8, pixel width.
- LINE_SIZE_MAX, 1024, max pixels per line; bank depth.
- ADDR_WIDTH, 10, RAM address width; must satisfy 2^ADDR_WIDTH >= LINE_SIZE_MAX.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Synchronous, active-high.
- line_size  in  16  output pixels per line (N), 1..LINE_SIZE_MAX. Sampled at each input line start.
- h_gap  in  16  minimum idle cycles before each output line; 0 is treated as 1.
- di_i  in  DATA_WIDTH  input pixel.
- de_i  in  1  input pixel valid.
- hs_i  in  1  first pixel of line; qualified by de_i.
- vs_i  in  1  first pixel of frame; qualified by de_i; implies hs_i.
- do_o  out  DATA_WIDTH  output pixel.
- de_o  out  1  output valid.
- hs_o  out  1  one-cycle pulse with the first pixel of each output line.
- vs_o  out  1  one-cycle pulse with the first pixel of the first line of a frame.
- ovf_o  out  1  sticky flag: an input line was dropped because no bank was free.
- ovf_cnt_o  out  16  dropped-line counter; see Optional Feature.

Behaviour:
- Reset:
  - do_o=0, de_o=0, hs_o=0, vs_o=0, ovf_o=0, ovf_cnt_o=0.
  - Both banks empty; wr_bank=0, rd_bank=0; write counter 0; read FSM in IDLE.
  - Reset mid-line aborts both sides; de_o is 0 from the cycle after the reset edge.
- Write side (acts only when de_i=1):
  - Line start (hs_i or vs_i):
    - Target bank is wr_bank. If full[wr_bank]=1, set drop mode: ignore the line's pixels, set ovf_o, increment the counter.
    - Otherwise: latch line_size into len[wr_bank]; latch sof[wr_bank]=vs_i; write di_i at address 0; wr_cnt=1.
  - Subsequent valid pixels write at wr_cnt, then increment wr_cnt.
  - When the pixel at address len-1 is written: full[wr_bank]<=1 and wr_bank toggles.
  - Pixels after len-1 and before the next line start are ignored.
  - A new line start before len pixels arrive discards the partial line: bank not marked full, wr_bank unchanged, rewrite from address 0.
  - de_i with no line start ever seen since reset: ignored.
- Read FSM, states IDLE, GAP, ACTIVE:
  - IDLE: if full[rd_bank], go to GAP and load gap counter with max(h_gap,1).
  - GAP: decrement the counter; at 1, go to ACTIVE with rd_addr=0.
  - ACTIVE: issue one RAM read per cycle; rd_addr increments. After address len[rd_bank]-1 is issued: clear full[rd_bank], toggle rd_bank, go to IDLE.
  - Never emit from a bank that is not full.
- Output pipeline:
  - RAM read is registered (1 cycle); outputs are registered (1 cycle).
  - de_o follows the ACTIVE read-issue strobe by 2 cycles.
  - hs_o = de_o of address 0.
  - vs_o = hs_o AND sof of that bank.
  - do_o holds its last value when de_o=0.
- Latency: last input pixel accepted at edge E, read FSM idle → first de_o at edge E+max(h_gap,1)+3.
- Output burst: exactly len consecutive de_o cycles. Gap between consecutive output lines is at least max(h_gap,1)+1 cycles.
- Same-bank write and read in one cycle cannot occur; guaranteed by the full flags. full[] set and clear in the same cycle act on different banks.
- Throughput: no drops while the average input line period ≥ len+max(h_gap,1)+1 cycles.

Optional Feature:
- Macro SCALER_V_LINE_PACK_OVF_CNT_EN.
- Defined: ovf_cnt_o is a 16-bit counter of dropped lines, saturating at 0xFFFF, cleared only by rst.
- Undefined: ovf_cnt_o is tied to 0 and no counter logic is built; ovf_o behaviour is unchanged.

Test Plan:
- line_size=4, h_gap=2; one line of pixels 0x10..0x13 with de_i on every third cycle, vs_i+hs_i on the first pixel → de_o high for 4 consecutive cycles carrying 0x10,0x11,0x12,0x13; hs_o and vs_o high on 0x10 only; first de_o at E+5.
- Three 4-pixel lines back-to-back, vs only on line 1 → three bursts in order; vs_o only on the first burst; gaps between bursts ≥3 cycles.
- h_gap=200, line_size=4, three lines arriving faster than they drain → third line dropped; ovf_o=1; ovf_cnt_o=1 with the macro, 0 without; lines 1 and 2 output intact.
- Short line: hs_i, 2 pixels, then hs_i and 4 pixels 0xA0..0xA3 → only one burst, 0xA0..0xA3.
- line_size=1024 with h_gap=0 → 1024-cycle burst; gap treated as 1; address wrap correct.
- rst asserted in the middle of an output burst → de_o=0 from the next cycle; a fresh line afterwards is emitted from bank 0 correctly.
